// File: rtl/mac_array_seq_pkg.sv
// Shared encodings for the MAC array sequencer: FSM states and array instructions.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_array_seq_if.sv
// Sequencer bus: core start/done handshake, array instruction/valid, SRAM read port.
interface mac_array_seq_if #(
  parameter int COL     = 8,
  parameter int LEN_BW  = 8,
  parameter int ADDR_BW = 11
);
  logic               start;
  logic [LEN_BW-1:0]  num_vec;
  logic [ADDR_BW-1:0] w_base;
  logic [ADDR_BW-1:0] x_base;
  logic [COL-1:0]     valid;
  logic               w_rd_en;
  logic               x_rd_en;
  logic [ADDR_BW-1:0] rd_addr;
  logic [1:0]         inst_w;
  logic               busy;
  logic               done;
  logic               err;
  logic [LEN_BW-1:0]  out_cnt;

  // master = core/array side, slave = the sequencer
  modport master (
    output start, num_vec, w_base, x_base, valid,
    input  w_rd_en, x_rd_en, rd_addr, inst_w, busy, done, err, out_cnt
  );

  modport slave (
    input  start, num_vec, w_base, x_base, valid,
    output w_rd_en, x_rd_en, rd_addr, inst_w, busy, done, err, out_cnt
  );
endinterface

// File: rtl/mac_array_seq_counter.sv
// Loadable saturating up-counter with terminal-count compare on the current value.
module seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)                          cnt_d = ld_val_i;
    else if (inc_i && (cnt_q != '1))   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;
  assign tc_o  = (cnt_q == term_i);
endmodule

// File: rtl/mac_array_seq.sv
// Tile sequencer for the systolic MAC array: kernel load, activation stream, drain.
module mac_array_seq
  import mac_pkg::*;
#(
  parameter int COL       = 8,
  parameter int LEN_BW    = 8,
  parameter int ADDR_BW   = 11,
  parameter int DRAIN_MAX = 64
) (
  input  logic            clk,
  input  logic            reset,
  mac_array_seq_if.slave  bus
);
  localparam int TW = $clog2(DRAIN_MAX + 1);

  state_t             state_q, state_d;
  logic [LEN_BW-1:0]  nv_q;
  logic [ADDR_BW-1:0] wb_q, xb_q;
  logic               err_q;
  logic [1:0]         inst_q, inst_d;
  logic               acc, cmpl;

  logic               cyc_ld, cyc_inc, cyc_tc;
  logic [LEN_BW-1:0]  cyc_cnt, cyc_term, cyc_nxt_unused;
  logic               oc_inc, oc_tc_unused;
  logic [LEN_BW-1:0]  oc_cnt, oc_nxt;
  logic               tmo_ld, tmo_inc, tmo_tc;
  logic [TW-1:0]      tmo_cnt_unused, tmo_nxt_unused;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (cyc_tc)    state_d = (nv_q != '0) ? EXEC : FIN;
      EXEC:    if (cyc_tc)    state_d = DRAIN;
      DRAIN:   if (cmpl || tmo_tc) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc         = (state_q == IDLE) && bus.start;
    bus.w_rd_en = (state_q == LOAD);
    bus.x_rd_en = (state_q == EXEC);
    bus.rd_addr = '0;
    if (state_q == LOAD) bus.rd_addr = wb_q + ADDR_BW'(cyc_cnt);
    if (state_q == EXEC) bus.rd_addr = xb_q + ADDR_BW'(cyc_cnt);
    bus.busy    = state_q inside {LOAD, EXEC, DRAIN};
    bus.done    = (state_q == FIN);
    // SRAM data lands one cycle after the strobe, so the instruction trails the read state
    inst_d      = (state_q == LOAD) ? INST_LOAD :
                  (state_q == EXEC) ? INST_EXEC : INST_IDLE;
    cyc_ld      = (state_q == IDLE) || ((state_q == LOAD) && cyc_tc);
    cyc_inc     = (state_q == LOAD) || (state_q == EXEC);
    cyc_term    = (state_q == EXEC) ? nv_q - LEN_BW'(1) : LEN_BW'(COL - 1);
    oc_inc      = bus.valid[COL-1] && (state_q inside {EXEC, DRAIN, FIN});
    tmo_ld      = (state_q != DRAIN);
    tmo_inc     = (state_q == DRAIN);
    // completion is judged on the count including this cycle's row and beats a timeout
    cmpl        = (oc_nxt == nv_q);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      nv_q   <= '0;
      wb_q   <= '0;
      xb_q   <= '0;
      err_q  <= 1'b0;
      inst_q <= INST_IDLE;
    end else begin
      inst_q <= inst_d;
      if (acc) begin
        nv_q  <= bus.num_vec;
        wb_q  <= bus.w_base;
        xb_q  <= bus.x_base;
        err_q <= 1'b0;
      end else if ((state_q == DRAIN) && !cmpl && tmo_tc) begin
        err_q <= 1'b1;
      end
    end

  seq_counter #(.W(LEN_BW)) u_cyc (
    .clk(clk), .rst_n(reset), .ld_i(cyc_ld), .ld_val_i('0), .inc_i(cyc_inc),
    .term_i(cyc_term), .cnt_o(cyc_cnt), .nxt_o(cyc_nxt_unused), .tc_o(cyc_tc)
  );

  seq_counter #(.W(LEN_BW)) u_oc (
    .clk(clk), .rst_n(reset), .ld_i(acc), .ld_val_i('0), .inc_i(oc_inc),
    .term_i(nv_q), .cnt_o(oc_cnt), .nxt_o(oc_nxt), .tc_o(oc_tc_unused)
  );

  seq_counter #(.W(TW)) u_tmo (
    .clk(clk), .rst_n(reset), .ld_i(tmo_ld), .ld_val_i('0), .inc_i(tmo_inc),
    .term_i(TW'(DRAIN_MAX - 1)), .cnt_o(tmo_cnt_unused), .nxt_o(tmo_nxt_unused), .tc_o(tmo_tc)
  );

  assign bus.inst_w  = inst_q;
  assign bus.err     = err_q;
  assign bus.out_cnt = oc_cnt;
endmodule

// File: tb/tb_mac_array_seq.sv
// Scoreboard bench for mac_array_seq with a simple array model (valid 4 cycles after each exec).
module tb_mac_array_seq;
  import mac_pkg::*;

  localparam int COL = 8, LEN_BW = 8, ADDR_BW = 11, DRAIN_MAX = 64;

  typedef struct { bit w; logic [ADDR_BW-1:0] addr; } rd_t;
  typedef struct { int cyc; int cnt; bit err; } dn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  mac_array_seq_if #(.COL(COL), .LEN_BW(LEN_BW), .ADDR_BW(ADDR_BW)) bus ();

  mac_array_seq #(.COL(COL), .LEN_BW(LEN_BW), .ADDR_BW(ADDR_BW), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0, pulse_lim = 0, pcnt = 0;
  rd_t rd_q[$];
  dn_t dn_q[$];
  logic [3:0]     pipe = '0;
  logic [COL-2:0] noise = '0;
  logic           stray = 1'b0;
  logic [1:0]     prev_inst = INST_IDLE;

  assign bus.valid = {pipe[3] | stray, noise};

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // array model: valid[COL-1] four cycles after each exec instruction, up to pulse_lim per tile
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= (COL-1)'($urandom);
    pipe  <= {pipe[2:0], bus.busy && (bus.inst_w == INST_EXEC) && (pcnt < pulse_lim)};
    if (!bus.busy) pcnt <= 0;
    else if ((bus.inst_w == INST_EXEC) && (pcnt < pulse_lim)) pcnt <= pcnt + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) prev_inst <= INST_IDLE;
    else begin
      chk("inst_w", bus.inst_w, prev_inst);
      prev_inst <= INST_IDLE;
      if (bus.w_rd_en || bus.x_rd_en) begin
        if (rd_q.size() == 0) chk("rd_extra", 1, 0);
        else begin
          chk("rd_kind", {bus.w_rd_en, bus.x_rd_en}, {rd_q[0].w, !rd_q[0].w});
          chk("rd_addr", bus.rd_addr, rd_q[0].addr);
          prev_inst <= rd_q[0].w ? INST_LOAD : INST_EXEC;
          rd_q.delete(0);
        end
      end
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        if (dn_q.size() == 0) chk("done_extra", 1, 0);
        else begin
          chk("done_cyc", cyc, dn_q[0].cyc);
          chk("out_cnt", bus.out_cnt, dn_q[0].cnt);
          chk("err", bus.err, dn_q[0].err);
          chk("busy_fin", bus.busy, 0);
          dn_q.delete(0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_reads(input int wb, input int xb, input int n);
    for (int k = 0; k < COL; k++) rd_q.push_back('{1'b1, ADDR_BW'(wb + k)});
    for (int j = 0; j < n; j++)   rd_q.push_back('{1'b0, ADDR_BW'(xb + j)});
  endtask

  task automatic run_tile(input int n, input int wb, input int xb, input int lim, input int lat,
                          input int ecnt, input bit eerr, input bit poke);
    bit seen = 1'b0;
    tick();
    bus.start   = 1'b1;
    bus.num_vec = LEN_BW'(n);
    bus.w_base  = ADDR_BW'(wb);
    bus.x_base  = ADDR_BW'(xb);
    pulse_lim   = lim;
    push_reads(wb, xb, n);
    dn_q.push_back('{cyc + lat, ecnt, eerr});
    for (int i = 1; i <= lat + 10 && !seen; i++) begin
      tick();
      bus.start = 1'b0;
      if (poke && (i == 3 || i == COL + 2)) begin
        bus.start   = 1'b1;
        bus.num_vec = LEN_BW'($urandom);
        bus.w_base  = ADDR_BW'($urandom);
        bus.x_base  = ADDR_BW'($urandom);
      end
      if (i == 1) begin
        chk("busy_acc", bus.busy, 1);
        chk("err_clr", bus.err, 0);
      end
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    if (poke) begin
      bus.start   = 1'b1;
      bus.num_vec = 8'h55;
    end
  endtask

  initial begin
    int n, d0;
    bus.start = 1'b0; bus.num_vec = '0; bus.w_base = '0; bus.x_base = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_inst", bus.inst_w, 0);
    chk("rst_wrd", bus.w_rd_en, 0);
    chk("rst_xrd", bus.x_rd_en, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_cnt", bus.out_cnt, 0);
    rst_n = 1'b1;

    run_tile(4, 'h10, 'h40, 99, COL + 4 + 6, 4, 1'b0, 1'b1);
    run_tile(0, 'h20, 'h55, 99, COL + 1, 0, 1'b0, 1'b0);
    run_tile(3, 'h100, 'h200, 2, COL + 3 + 1 + DRAIN_MAX, 2, 1'b1, 1'b0);

    tick(); stray = 1'b1;
    tick(); stray = 1'b0;
    tick();
    chk("idle_cnt", bus.out_cnt, 2);
    chk("idle_err", bus.err, 1);
    chk("idle_busy", bus.busy, 0);

    run_tile(4, 'h7FC, 'h7FE, 99, COL + 4 + 6, 4, 1'b0, 1'b0);

    tick();
    bus.start = 1'b1; bus.num_vec = 8'd4; bus.w_base = 'h30; bus.x_base = 'h50;
    pulse_lim = 99;
    push_reads('h30, 'h50, 2);
    for (int i = 1; i <= COL + 3; i++) begin
      tick();
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_inst", bus.inst_w, 0);
    chk("mid_wrd", bus.w_rd_en, 0);
    chk("mid_xrd", bus.x_rd_en, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    d0 = done_cnt;
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("mid_nodone", done_cnt, d0);
    chk("mid_idle", bus.busy, 0);
    chk("mid_cnt", bus.out_cnt, 0);

    n = $urandom_range(1, 6);
    run_tile(n, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 99,
             COL + n + 6, n, 1'b0, 1'b0);

    repeat (5) tick();
    chk("rd_left", rd_q.size(), 0);
    chk("done_left", dn_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
